sdr_cmd_arbiter: RTL and testbench

Command-bus arbiter and sequencer for the SDRAM controller. Sits between the Avalon-side request logic and the four SDRAM sub-FSMs (init, auto-refresh, write, read). Grants exactly one sub-FSM at a time, with priority order refresh > write/read and write/read alternating. Starts the granted FSM with a one-cycle enable pulse, waits for its done edge, and multiplexes that FSM's 20-bit command/address bus onto the SDRAM pins.

---
 rtl/sdr_cmd_arbiter.sv | 143 ++++++++++++++
 tb/tb_sdr_cmd_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdr_cmd_arbiter.sv
// SDRAM command-bus arbiter: grants one sub-FSM at a time (refresh first, write/read
// alternating), pulses its enable, then muxes its command bus until its done edge.
module sdr_cmd_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        soft_rst,
  input  logic        init_done,
  input  logic [19:0] init_bus,
  input  logic        ref_req,
  input  logic        wr_req,
  input  logic        rd_req,
  input  logic        ref_done,
  input  logic        wr_done,
  input  logic        rd_done,
  input  logic [19:0] ref_bus,
  input  logic [19:0] wr_bus,
  input  logic [19:0] rd_bus,
  output logic        ref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic        ref_ack,
  output logic        wr_ack,
  output logic        rd_ack,
  output logic        ref_cmp,
  output logic        wr_cmp,
  output logic        rd_cmp,
  output logic [19:0] sdr_bus,
  output logic        busy,
  output logic        err,
  output logic [4:0]  dbg_state
);

  // Handshake: *_req is a level held until *_ack; *_ack and *_en are a single-cycle
  // pulse in the IDLE cycle that decides, and the requester drops *_req the next cycle
  // or is granted again after the transaction completes.

  localparam logic [3:0]  NOP      = 4'b0111;
  localparam logic [19:0] NOP_WORD = {NOP, 13'd0, 2'd0, 1'b1};
  localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [4:0] {
    ST_INIT = 5'b00001,
    ST_IDLE = 5'b00010,
    ST_REF  = 5'b00100,
    ST_WR   = 5'b01000,
    ST_RD   = 5'b10000
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] req_q, req_d;
  logic [2:0] done_q, done_d;
  logic [2:0] grant;
  logic [2:0] own;
  logic [2:0] done_rise;
  logic       last_rd_q, last_rd_d;
  logic       busy_q, busy_d;
  logic [7:0] cnt_q, cnt_d;
  logic       fsm_done;
  logic       tmo_hit;

  // Bit order for all per-FSM vectors: [0] refresh, [1] write, [2] read.
  always_ff @(posedge clk) begin
    if (soft_rst) begin
      state_q   <= ST_INIT;
      req_q     <= '0;
      done_q    <= '0;
      last_rd_q <= 1'b1;
      cnt_q     <= '0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      done_q    <= done_d;
      last_rd_q <= last_rd_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    req_d     = {rd_req, wr_req, ref_req};
    done_d    = {rd_done, wr_done, ref_done};
    own       = {state_q == ST_RD, state_q == ST_WR, state_q == ST_REF};
    done_rise = done_d & ~done_q;
    fsm_done  = |(done_rise & own);
    tmo_hit   = (|own) && (cnt_q == TMO_LAST);
    grant     = 3'b000;
    if (state_q == ST_IDLE) begin
      if (req_q[0])                 grant = 3'b001;
      else if (req_q[1] && req_q[2]) grant = last_rd_q ? 3'b010 : 3'b100;
      else if (req_q[1])            grant = 3'b010;
      else if (req_q[2])            grant = 3'b100;
    end

    state_d = state_q;
    unique case (state_q)
      ST_INIT: if (init_done) state_d = ST_IDLE;
      ST_IDLE: begin
        if (grant[0])      state_d = ST_REF;
        else if (grant[1]) state_d = ST_WR;
        else if (grant[2]) state_d = ST_RD;
      end
      ST_REF, ST_WR, ST_RD: if (fsm_done || tmo_hit) state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase

    last_rd_d = last_rd_q;
    if (grant[1])      last_rd_d = 1'b0;
    else if (grant[2]) last_rd_d = 1'b1;

    cnt_d = cnt_q;
    if (|grant)    cnt_d = '0;
    else if (|own) cnt_d = cnt_q + 8'd1;

    busy_d = (state_d != ST_IDLE);
  end

  // Pulses are suppressed while reset is asserted so an aborted transaction reports nothing.
  always_comb begin
    ref_en    = grant[0] & ~soft_rst;
    wr_en     = grant[1] & ~soft_rst;
    rd_en     = grant[2] & ~soft_rst;
    ref_ack   = grant[0] & ~soft_rst;
    wr_ack    = grant[1] & ~soft_rst;
    rd_ack    = grant[2] & ~soft_rst;
    ref_cmp   = done_rise[0] & own[0] & ~soft_rst;
    wr_cmp    = done_rise[1] & own[1] & ~soft_rst;
    rd_cmp    = done_rise[2] & own[2] & ~soft_rst;
    err       = tmo_hit & ~fsm_done & ~soft_rst;
    busy      = busy_q;
    dbg_state = state_q;
    unique case (state_q)
      ST_INIT: sdr_bus = init_bus;
      ST_IDLE: sdr_bus = NOP_WORD;
      ST_REF:  sdr_bus = ref_bus;
      ST_WR:   sdr_bus = wr_bus;
      ST_RD:   sdr_bus = rd_bus;
      default: sdr_bus = init_bus;
    endcase
  end

endmodule

// File: tb/tb_sdr_cmd_arbiter.sv
// Randomized bench for sdr_cmd_arbiter: a scenario driver pushes expected pulse events
// into a queue and tracks the expected bus owner; a negedge monitor checks both.
module tb_sdr_cmd_arbiter;

  localparam int          TMO      = 8;
  localparam logic [19:0] NOP_WORD = 20'h70001;
  localparam int O_INIT = 0, O_IDLE = 1, O_REF = 2, O_WR = 3, O_RD = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        soft_rst, init_done;
  logic [19:0] init_bus, ref_bus, wr_bus, rd_bus;
  logic [2:0]  req_v, done_v;
  logic        ref_en, wr_en, rd_en, ref_ack, wr_ack, rd_ack;
  logic        ref_cmp, wr_cmp, rd_cmp, busy, err;
  logic [19:0] sdr_bus;
  logic [4:0]  dbg_state;

  sdr_cmd_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .soft_rst(soft_rst), .init_done(init_done), .init_bus(init_bus),
    .ref_req(req_v[0]), .wr_req(req_v[1]), .rd_req(req_v[2]),
    .ref_done(done_v[0]), .wr_done(done_v[1]), .rd_done(done_v[2]),
    .ref_bus(ref_bus), .wr_bus(wr_bus), .rd_bus(rd_bus),
    .ref_en(ref_en), .wr_en(wr_en), .rd_en(rd_en),
    .ref_ack(ref_ack), .wr_ack(wr_ack), .rd_ack(rd_ack),
    .ref_cmp(ref_cmp), .wr_cmp(wr_cmp), .rd_cmp(rd_cmp),
    .sdr_bus(sdr_bus), .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scenario state
  int          own = O_INIT;
  int          locked = -1;
  bit          init_rand = 0;
  bit          arrive_en = 0;
  bit          mon_en = 0;
  int          grant_log[$];
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;

  // event codes: 0..2 en (ref/wr/rd), 3..5 ack, 6..8 cmp, 9 err
  task automatic expect_ev(input int code);
    exp_q.push_back({cyc[23:0], 8'(code)});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    init_bus = 20'($urandom);
    ref_bus  = 20'($urandom);
    wr_bus   = 20'($urandom);
    rd_bus   = 20'($urandom);
    for (int i = 0; i < 3; i++)
      if (i != locked) done_v[i] = 1'($urandom_range(0, 1));
    if (init_rand) init_done = 1'($urandom_range(0, 1));
  endtask

  // Winner from request levels: refresh first; a write/read tie goes to whichever
  // of the two was not granted most recently (write when neither has been granted).
  function automatic int pick(input logic [2:0] r);
    int last = 2;
    for (int i = 0; i < grant_log.size(); i++)
      if (grant_log[i] != 0) last = grant_log[i];
    if (r[0]) return 0;
    if (r[1] && r[2]) return (last == 2) ? 1 : 2;
    if (r[1]) return 1;
    return 2;
  endfunction

  // Called in an IDLE cycle whose registered requests equal req_v.
  // req_mode: 0 winner drops, 1 everyone keeps requesting, 2 everyone drops.
  task automatic serve(input int k_in, input int stale_in, input bit never, input int req_mode);
    int w, k;
    bit stale;
    w = pick(req_v);
    grant_log.push_back(w);
    expect_ev(w);
    expect_ev(3 + w);
    stale = (stale_in < 0) ? 1'($urandom_range(0, 1)) : 1'(stale_in);
    k = (k_in >= 0) ? k_in : $urandom_range(0, TMO - 1);
    if (stale && k == 0) k = 1;
    locked = w;
    done_v[w] = stale;
    next_cycle();
    own = O_REF + w;
    if (req_mode == 0) req_v[w] = 1'b0;
    else if (req_mode == 2) req_v = 3'b000;
    for (int j = 0; j < TMO; j++) begin
      if (j > 0) next_cycle();
      if (arrive_en && $urandom_range(0, 3) == 0) req_v[$urandom_range(0, 2)] = 1'b1;
      if (!never && j == k) begin
        done_v[w] = 1'b1;
        expect_ev(6 + w);
        break;
      end
      if (!never && j == k - 1) done_v[w] = 1'b0;
      if (never && j == TMO - 1) begin
        expect_ev(9);
        break;
      end
    end
    next_cycle();
    own = O_IDLE;
    locked = -1;
  endtask

  // monitor / scoreboard
  logic [9:0]  ev_now;
  logic [19:0] bus_exp;
  logic [31:0] e;
  always @(negedge clk) begin
    if (mon_en) begin
      case (own)
        O_INIT:  bus_exp = init_bus;
        O_IDLE:  bus_exp = NOP_WORD;
        O_REF:   bus_exp = ref_bus;
        O_WR:    bus_exp = wr_bus;
        default: bus_exp = rd_bus;
      endcase
      checks++;
      if (sdr_bus !== bus_exp) begin
        failures++;
        $display("FAIL sdr_bus cyc=%0d got=%h required=%h", cyc, sdr_bus, bus_exp);
      end
      checks++;
      if (busy !== (own != O_IDLE)) begin
        failures++;
        $display("FAIL busy cyc=%0d got=%b required=%b", cyc, busy, own != O_IDLE);
      end
      while (exp_q.size() > 0 && exp_q[0][31:8] < cyc[23:0]) begin
        e = exp_q.pop_front();
        checks++;
        failures++;
        $display("FAIL event_missing cyc=%0d got=none required=code%0d@%0d", cyc, e[7:0], e[31:8]);
      end
      ev_now = {err, rd_cmp, wr_cmp, ref_cmp, rd_ack, wr_ack, ref_ack, rd_en, wr_en, ref_en};
      for (int i = 0; i < 10; i++) begin
        if (ev_now[i] !== 1'b0) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL event_unexpected cyc=%0d got=code%0d required=none", cyc, i);
          end else begin
            e = exp_q.pop_front();
            if (e !== {cyc[23:0], 8'(i)}) begin
              failures++;
              $display("FAIL event cyc=%0d got=code%0d@%0d required=code%0d@%0d",
                       cyc, i, cyc, e[7:0], e[31:8]);
            end
          end
        end
      end
    end
  end

  // stimulus
  initial begin
    soft_rst = 1'b1;
    init_done = 1'b0;
    init_bus = '0; ref_bus = '0; wr_bus = '0; rd_bus = '0;
    req_v = 3'b000;
    done_v = 3'b000;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    next_cycle();
    next_cycle();

    // init: done at cycle 10 after reset release, IDLE from cycle 11
    for (int i = 0; i <= 10; i++) begin
      next_cycle();
      if (i == 0) soft_rst = 1'b0;
      init_bus = 20'hABCDE;
      init_done = (i == 10);
    end
    next_cycle();
    own = O_IDLE;
    init_rand = 1'b1;

    // priority: REF first, then WR/RD alternate while both held
    req_v = 3'b111;
    next_cycle();
    serve(-1, -1, 1'b0, 0);
    serve(-1, -1, 1'b0, 1);
    serve(-1, -1, 1'b0, 1);
    serve(-1, -1, 1'b0, 2);

    // single write, done edge 4 cycles after wr_en
    req_v = 3'b010;
    next_cycle();
    serve(3, 0, 1'b0, 0);

    // stale wr_done level at grant
    req_v = 3'b010;
    next_cycle();
    serve(3, 1, 1'b0, 0);

    // read timeout, plain and with stale done; done on the last allowed cycle
    req_v = 3'b100;
    next_cycle();
    serve(0, 0, 1'b1, 0);
    req_v = 3'b100;
    next_cycle();
    serve(0, 1, 1'b1, 0);
    req_v = 3'b100;
    next_cycle();
    serve(TMO - 1, 0, 1'b0, 0);

    // randomized traffic
    arrive_en = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if (req_v == 3'b000) begin
        repeat ($urandom_range(0, 2)) next_cycle();
        req_v = 3'($urandom_range(1, 7));
        if ($urandom_range(0, 2) != 0) req_v[0] = 1'b0;
        if (req_v == 3'b000) req_v = 3'b010;
        next_cycle();
      end
      serve(-1, -1, ($urandom_range(0, 7) == 0), $urandom_range(0, 2));
    end
    arrive_en = 1'b0;
    while (req_v != 3'b000) serve(-1, -1, 1'b0, 2);
    next_cycle();

    // reset in the middle of a write, with a done edge in the reset cycle
    req_v = 3'b010;
    next_cycle();
    grant_log.push_back(pick(req_v));
    expect_ev(1);
    expect_ev(4);
    locked = 1;
    done_v[1] = 1'b0;
    next_cycle();
    own = O_WR;
    req_v = 3'b000;
    next_cycle();
    next_cycle();
    soft_rst = 1'b1;
    done_v[1] = 1'b1;
    init_rand = 1'b0;
    init_done = 1'b0;
    next_cycle();
    soft_rst = 1'b0;
    own = O_INIT;
    locked = -1;
    grant_log.delete();
    repeat (3) next_cycle();
    init_done = 1'b1;
    next_cycle();
    own = O_IDLE;
    init_rand = 1'b1;
    req_v = 3'b110;
    next_cycle();
    serve(-1, -1, 1'b0, 0);
    serve(-1, -1, 1'b0, 0);

    repeat (3) next_cycle();
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_events got=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
